// File: rtl/inv_bvslt_bvashr_solver_pkg.sv
// Shared types, pos encoding and the saturating arithmetic shift for the
// bvslt/bvashr invertibility solver.
package inv_solver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic POS_VAL   = 1'b0;
    localparam logic POS_SHAMT = 1'b1;

    // Arithmetic right shift of the low w bits of v. Shift amounts of w or
    // more give all sign bits. Bits above w-1 of the result are don't-care.
    function automatic logic [63:0] sra_sat(input logic [63:0] v,
                                            input logic [63:0] sh,
                                            input int unsigned w);
        logic [63:0] ext;
        logic        sign;
        sign = v[6'(w - 1)];
        ext  = v;
        for (int i = 0; i < 64; i++) begin
            if (i >= int'(w)) begin
                ext[i] = sign;
            end
        end
        if (sh >= 64'(w)) begin
            sra_sat = {64{sign}};
        end else begin
            sra_sat = 64'($signed(ext) >>> sh);
        end
    endfunction

endpackage

// File: rtl/inv_bvslt_bvashr_solver_pred.sv
// Combinational predicate: pos=0 -> (x >>a s) <s t, pos=1 -> (s >>a x) <s t.
// Pure logic, no state.
module inv_pred
    import inv_solver_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         pos,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    input  logic [W-1:0] x,
    output logic         sat
);

    logic [63:0]  w_val64;
    logic [63:0]  w_sh64;
    logic [W-1:0] w_res;

    always_comb begin
        w_val64 = '0;
        w_sh64  = '0;
        if (pos == POS_SHAMT) begin
            w_val64[W-1:0] = s;
            w_sh64[W-1:0]  = x;
        end else begin
            w_val64[W-1:0] = x;
            w_sh64[W-1:0]  = s;
        end
        w_res = W'(sra_sat(w_val64, w_sh64, W));
        sat   = $signed(w_res) < $signed(t);
    end

endmodule

// File: rtl/inv_bvslt_bvashr_solver.sv
// Sequential witness search for (x >>a s) <s t / (s >>a x) <s t; latency 2 (pos=0) or k+2 / W+2 (pos=1).
// Holds the result in DONE until out_ready; in_ready only in IDLE. Optional checker: INV_SOLVER_SELFCHECK_EN.
module inv_bvslt_bvashr_solver
    import inv_solver_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         pos,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x,
    output logic         found,
    output logic         err
);

    localparam int            KW     = $clog2(W + 1);
    localparam logic [W-1:0]  MIN    = {1'b1, {(W-1){1'b0}}};
    localparam logic [KW-1:0] K_LAST = KW'(W);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_pos;
    logic [W-1:0]  r_s;
    logic [W-1:0]  r_t;
    logic [W-1:0]  r_x;
    logic          r_found;
    logic [KW-1:0] r_k;
    logic [KW-1:0] w_k_nxt;
    logic [W-1:0]  w_x_nxt;
    logic          w_found_nxt;
    logic          w_accept;
    logic [W-1:0]  w_cand;
    logic          w_last;
    logic          w_sat;

    // MIN >>a s is the smallest reachable value, so pos=0 needs one candidate.
    assign w_cand = (r_pos == POS_VAL) ? MIN : W'(r_k);
    assign w_last = (r_pos == POS_VAL) || (r_k == K_LAST);

    inv_pred #(.W(W)) u_scan (
        .pos (r_pos),
        .s   (r_s),
        .t   (r_t),
        .x   (w_cand),
        .sat (w_sat)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_x_nxt     = r_x;
        w_found_nxt = r_found;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SCAN;
                    w_k_nxt     = '0;
                    w_x_nxt     = '0;
                    w_found_nxt = 1'b0;
                end
            end
            SCAN: begin
                if (w_sat) begin
                    w_x_nxt     = w_cand;
                    w_found_nxt = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_last) begin
                    w_x_nxt     = '0;
                    w_found_nxt = 1'b0;
                    w_state_nxt = DONE;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_pos   <= POS_VAL;
            r_s     <= '0;
            r_t     <= '0;
            r_x     <= '0;
            r_found <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_x     <= w_x_nxt;
            r_found <= w_found_nxt;
            if (w_accept) begin
                r_pos <= pos;
                r_s   <= s;
                r_t   <= t;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign x         = r_x;
    assign found     = r_found;

`ifdef INV_SOLVER_SELFCHECK_EN
    logic         w_chk_sat;
    logic [W-1:0] w_min_sh;
    logic         w_closed;
    logic         r_err;

    inv_pred #(.W(W)) u_chk (
        .pos (r_pos),
        .s   (r_s),
        .t   (r_t),
        .x   (r_x),
        .sat (w_chk_sat)
    );

    assign w_min_sh = W'(sra_sat(64'(MIN), 64'(r_s), W));
    assign w_closed = $signed(w_min_sh) < $signed(r_t);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == DONE &&
                     ((r_found && !w_chk_sat) ||
                      (!r_found && r_pos == POS_VAL && w_closed))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_inv_bvslt_bvashr_solver.sv
// Randomized and directed bench for inv_bvslt_bvashr_solver at W=4 against an
// exhaustive-search reference built on integer floor division.
module tb_inv_bvslt_bvashr_solver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         pos;
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] x;
    logic         found;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inv_bvslt_bvashr_solver #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pos       (pos),
        .s         (s),
        .t         (t),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .found     (found),
        .err       (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int to_signed(input logic [3:0] v);
        return (v >= 4'd8) ? int'(v) - 16 : int'(v);
    endfunction

    // Arithmetic shift right by n is floor division by 2**n.
    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    // Searches every possible x; pos=0 witness is MIN, pos=1 witness is the
    // smallest satisfying shift amount.
    task automatic model(input logic p, input logic [3:0] sv, input logic [3:0] tv,
                         output logic f, output logic [3:0] xe, output int lat);
        int b;
        f   = 1'b0;
        xe  = 4'd0;
        lat = p ? W + 2 : 2;
        b   = to_signed(tv);
        for (int xi = 0; xi < 16; xi++) begin
            if (!p) begin
                if (floor_div(to_signed(4'(xi)), 1 << sv) < b) f = 1'b1;
            end else if (!f && floor_div(to_signed(sv), 1 << xi) < b) begin
                f   = 1'b1;
                xe  = 4'(xi);
                lat = xi + 2;
            end
        end
        if (!p && f) xe = 4'b1000;
    endtask

    task automatic run_req(input logic p, input logic [3:0] sv, input logic [3:0] tv, input int hold);
        logic       ef;
        logic [3:0] ex;
        int         lat;
        int         g;
        int         c;
        model(p, sv, tv, ef, ex, lat);
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("accept_rdy", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        pos      = p;
        s        = sv;
        t        = tv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pos      = 1'($urandom);
        s        = 4'($urandom);
        t        = 4'($urandom);
        c = 1;
        @(negedge clk);
        while (!out_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("latency", 64'(c), 64'(lat));
        check("found", 64'(found), 64'(ef));
        check("x", 64'(x), 64'(ex));
        check("busy_rdy", 64'(in_ready), 64'd0);
        check("err", 64'(err), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_vld", 64'(out_valid), 64'd1);
            check("hold_x", 64'(x), 64'(ex));
            check("hold_found", 64'(found), 64'(ef));
            check("hold_rdy", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_rdy", 64'(in_ready), 64'd1);
        check("idle_vld", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int stray;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pos       = 1'b0;
        s         = '0;
        t         = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", 64'(in_ready), 64'd1);
        check("rst_vld", 64'(out_valid), 64'd0);
        check("rst_x", 64'(x), 64'd0);
        check("rst_found", 64'(found), 64'd0);
        check("rst_err", 64'(err), 64'd0);

        run_req(1'b0, 4'd0, 4'b1000, 0);
        run_req(1'b0, 4'd1, 4'b1101, 0);
        run_req(1'b1, 4'b0110, 4'b0010, 0);
        run_req(1'b1, 4'b1000, 4'b1000, 0);
        run_req(1'b1, 4'b0110, 4'b0010, 3);
        run_req(1'b0, 4'd1, 4'b1101, 0);

        // Reset in cycle 3 of a long no-solution scan.
        @(negedge clk);
        in_valid = 1'b1;
        pos      = 1'b1;
        s        = 4'b1000;
        t        = 4'b1000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rdy", 64'(in_ready), 64'd1);
        check("mid_rst_vld", 64'(out_valid), 64'd0);
        check("mid_rst_x", 64'(x), 64'd0);
        check("mid_rst_found", 64'(found), 64'd0);
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check("no_stale_result", 64'(stray), 64'd0);
        run_req(1'b0, 4'd0, 4'b1000, 0);

        for (int n = 0; n < 80; n++) begin
            run_req(1'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inv_bvslt_bvashr_solver.md
# inv_bvslt_bvashr_solver

Sequential, parametrised solver for the invertibility problem `(x >>a s) <s t` and `(s >>a x) <s t` over W-bit bit-vectors. It returns a witness x, or reports that none exists. The block is the successor to the fixed 4-bit combinational Skolem-function netlists: width is a parameter, the unknown's operand position is selectable per request, and the block accepts and returns requests through valid/ready handshakes. It sits between the query front-end and the witness checker in the invertibility-condition flow.

## Interface
Parameters:
- `W`, default 4: operand width; legal range 2..64.

Ports:
- `clk`  in  1  the only clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request.
- `pos`  in  1  0: x is the shifted operand, `(x >>a s) <s t`; 1: x is the shift amount, `(s >>a x) <s t`.
- `s`  in  W  known operand.
- `t`  in  W  comparison bound (signed).
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result.
- `x`  out  W  witness; 0 when `found`=0.
- `found`  out  1  1 if the witness satisfies the predicate.
- `err`  out  1  sticky self-check failure flag (see Configuration).

## Operation
- FSM has three states: IDLE, SCAN and DONE.
  - IDLE: `in_ready`=1. On `in_valid`, capture `pos`, `s` and `t`, clear the candidate counter `k`, and go to SCAN.
  - SCAN: evaluate one candidate per cycle.
    - pos=0: there is a single candidate, x = MIN (1 followed by W-1 zeros). MIN >>a s is the minimum reachable value, so it is the only candidate needed.
    - pos=1: candidates are x = k for k = 0..W, in ascending order. Any shift of W or more gives all sign bits, so k=W covers every larger shift amount.
    - On the first candidate that satisfies the predicate: latch x, set found=1, go to DONE.
    - After the last candidate fails: latch x=0, found=0, go to DONE.
  - DONE: `out_valid`=1, and `x`/`found` are held stable. On `out_ready`, return to IDLE.
- The witness for pos=1 is the smallest satisfying shift amount.
- Arithmetic rules:
  - `>>a` is an arithmetic right shift; shift amounts ≥ W saturate to all sign bits.
  - `<s` is a two's-complement comparison.
  - `k` is $clog2(W+1) bits wide, zero-extended to W bits when it is driven onto `x`.
- `in_ready`=0 outside IDLE, so no new request is accepted while busy or while a result is held.
- Reset values: FSM=IDLE, `in_ready`=1 from the first cycle after reset, `out_valid`=0, `x`=0, `found`=0, `err`=0.
- Reset in mid-operation (SCAN or DONE) abandons the request; no result is produced.

## Timing
- Cycle 0 is the accept cycle (`in_valid` & `in_ready` sampled at its edge).
- Cycle 1 evaluates candidate 0. A match at candidate k gives `out_valid` high in cycle k+2.
- Latencies:
  - pos=0: `out_valid` in cycle 2.
  - pos=1, match at k: cycle k+2.
  - pos=1, no solution: cycle W+2.
- Outputs are registered; there is no combinational path from the inputs to `x`/`found`/`out_valid`.
- Throughput: one request per (latency + 1) cycles. The earliest next accept is the cycle after the DONE handshake, because IDLE must be entered first.

## Configuration
- `INV_SOLVER_SELFCHECK_EN` defined:
  - In DONE, an independent predicate instance re-evaluates the latched (pos, s, t, x).
  - `err` sets, and stays set until `rst`, if `found`=1 and the predicate is false.
  - `err` also sets if `found`=0, pos=0 and the closed-form condition `(MIN >>a s) <s t` is true.
- Not defined: `err` is tied to 0, the checker logic is absent, and the port stays present.

## Structure
- Package `inv_solver_pkg` holds:
  - the state enum (IDLE/SCAN/DONE);
  - the pos encoding constants `POS_VAL`=0 and `POS_SHAMT`=1;
  - the function `sra_sat(v, sh, W)`.
- Sub-module `inv_pred` is a combinational predicate (pos, s, t, x → sat). It is instantiated once for the scan and once more under the macro for the self-check.

## Test plan
All cases use W=4.
1. pos=0, s=0, t=4'b1000: −8<s−8 is false, so `found`=0, `x`=0, `out_valid` in cycle 2.
2. pos=0, s=1, t=4'b1101: MIN>>a1=−4 <s −3, so `found`=1, `x`=4'b1000, cycle 2.
3. pos=1, s=4'b0110, t=4'b0010: shifts 0 and 1 fail, shift 2 gives 1<2, so `x`=2, `found`=1, `out_valid` in cycle 4.
4. pos=1, s=4'b1000, t=4'b1000: results −8,−4,−2,−1,−1 all fail, so `found`=0, `x`=0, `out_valid` in cycle 6.
5. Case 3 with `out_ready` low for 3 cycles: `x`/`found` stay stable and `in_ready`=0. When `out_ready` goes high, the block is in IDLE the next cycle and accepts case 2.
6. `rst` pulsed in cycle 3 of case 4: the next cycle has `in_ready`=1, `out_valid`=0, `x`=0; no stale result appears, and a following case 1 completes normally.
